// File: rtl/la_ao211_pipe.sv
// Elastic pipeline computing z = (a0 & a1) | b0 | c0 per bit over STAGES slots.
// Optional sticky OR-accumulator of delivered results: define LA_AO211_PIPE_STICKY_EN.
module la_ao211_pipe #(
  parameter PROP = "DEFAULT",
  parameter int W = 8,
  parameter int STAGES = 2
) (
  input  logic         clk,
  input  logic         rst,
`ifdef LA_AO211_PIPE_STICKY_EN
  input  logic         sticky_clr,
  output logic [W-1:0] sticky,
`endif
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a0,
  input  logic [W-1:0] a1,
  input  logic [W-1:0] b0,
  input  logic [W-1:0] c0,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] z
);

  // Handshake: a transfer happens on a rising edge where valid & ready are both
  // high; valid never depends on ready, and data is only meaningful with valid.

  logic              unused_prop;
  logic [STAGES-1:0] valid_q, valid_d;
  logic [W-1:0]      data_q [STAGES];
  logic [W-1:0]      data_d [STAGES];
  logic [STAGES-1:0] slot_rdy;
  logic [W-1:0]      result;

  assign unused_prop = ^PROP;
  assign result = (a0 & a1) | b0 | c0;

  // A slot is ready when it, or any slot downstream of it, is empty, or the
  // consumer takes the last slot; this is the unrolled form of the ready chain.
  always_comb begin
    slot_rdy = '0;
    for (int k = 0; k < STAGES; k++) begin
      slot_rdy[k] = out_ready;
      for (int j = k; j < STAGES; j++) begin
        if (!valid_q[j]) slot_rdy[k] = 1'b1;
      end
    end
  end

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (slot_rdy[0]) begin
      valid_d[0] = in_valid;
      if (in_valid) data_d[0] = result;
    end
    for (int k = 1; k < STAGES; k++) begin
      if (slot_rdy[k]) begin
        valid_d[k] = valid_q[k-1];
        if (valid_q[k-1]) data_d[k] = data_q[k-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      for (int k = 0; k < STAGES; k++) data_q[k] <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign in_ready  = slot_rdy[0] & ~rst;
  assign out_valid = valid_q[STAGES-1];
  assign z         = data_q[STAGES-1];

`ifdef LA_AO211_PIPE_STICKY_EN
  logic [W-1:0] sticky_q, sticky_d;

  // Clear wins over an OR-in from a delivery in the same cycle.
  always_comb begin
    sticky_d = sticky_q;
    if (sticky_clr) sticky_d = '0;
    else if (out_valid && out_ready) sticky_d = sticky_q | z;
  end

  always_ff @(posedge clk) begin
    if (rst) sticky_q <= '0;
    else     sticky_q <= sticky_d;
  end

  assign sticky = sticky_q;
`endif

endmodule

// File: tb/tb_la_ao211_pipe.sv
// Bench for la_ao211_pipe: queue-based transaction model checked every cycle,
// plus directed vectors with hand-computed results.
module tb_la_ao211_pipe;
  localparam int W = 8;
  localparam int STAGES = 2;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b1;
  logic [W-1:0] a0 = '0, a1 = '0, b0 = '0, c0 = '0;
  logic         in_ready, out_valid;
  logic [W-1:0] z;
`ifdef LA_AO211_PIPE_STICKY_EN
  logic         sticky_clr = 1'b0;
  logic [W-1:0] sticky;
`endif

  la_ao211_pipe #(.PROP("DEFAULT"), .W(W), .STAGES(STAGES)) dut (
    .clk(clk),
    .rst(rst),
`ifdef LA_AO211_PIPE_STICKY_EN
    .sticky_clr(sticky_clr),
    .sticky(sticky),
`endif
    .in_valid(in_valid),
    .in_ready(in_ready),
    .a0(a0),
    .a1(a1),
    .b0(b0),
    .c0(c0),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .z(z)
  );

  // Clock / reset
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1, "watchdog");
  end

  int errors = 0;
  int checks = 0;
  int n_out = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] ao211(input logic [W-1:0] x0, input logic [W-1:0] x1,
                                         input logic [W-1:0] y0, input logic [W-1:0] w0);
    return (x0 & x1) | y0 | w0;
  endfunction

  // Scoreboard: accepted results in order, with the cycle each was accepted.
  logic [W-1:0] exp_q[$];
  int           age_q[$];
  logic [W-1:0] sticky_m = '0;
  bit           chk_en = 1'b0;

  always @(negedge clk) begin : cmp
    bit           e_rdy;
    bit           e_ov;
    bit           o_xfer;
    logic [W-1:0] head;
    if (chk_en) begin
      e_rdy = !rst && ((exp_q.size() < STAGES) || out_ready);
      e_ov  = (exp_q.size() > 0) && ((cyc - age_q[0]) >= STAGES);
      head  = (exp_q.size() > 0) ? exp_q[0] : '0;
      check("in_ready", in_ready, e_rdy);
      check("out_valid", out_valid, e_ov);
      if (e_ov) check("z", z, head);
`ifdef LA_AO211_PIPE_STICKY_EN
      check("sticky", sticky, sticky_m);
`endif
      o_xfer = e_ov && out_ready;
      if (o_xfer) begin
        void'(exp_q.pop_front());
        void'(age_q.pop_front());
        n_out++;
      end
      if (in_valid && e_rdy) begin
        exp_q.push_back(ao211(a0, a1, b0, c0));
        age_q.push_back(cyc);
      end
`ifdef LA_AO211_PIPE_STICKY_EN
      if (rst || sticky_clr) sticky_m = '0;
      else if (o_xfer) sticky_m = sticky_m | head;
`endif
      if (rst) begin
        exp_q.delete();
        age_q.delete();
      end
    end else if (rst) begin
      chk_en = 1'b1;
    end
  end

  // Driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ops(input logic [W-1:0] x0, input logic [W-1:0] x1,
                         input logic [W-1:0] y0, input logic [W-1:0] w0);
    a0 = x0; a1 = x1; b0 = y0; c0 = w0;
  endtask

`ifdef LA_AO211_PIPE_STICKY_EN
  task automatic pass_through(input logic [W-1:0] v, input logic clr);
    bit seen;
    set_ops('0, '0, v, '0);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    seen = 1'b0;
    for (int n = 0; n < 10; n++) begin
      if (out_valid) begin
        seen = 1'b1;
        break;
      end
      step();
    end
    if (!seen) begin
      errors++;
      checks++;
      $display("FAIL sticky_wait: got no out_valid required out_valid within 10 cycles");
    end
    sticky_clr = clr;
    step();
    sticky_clr = 1'b0;
  endtask
`endif

  int n0;

  initial begin
    // Model pins
    check("model_b1", ao211(8'hF0, 8'h3C, 8'h01, 8'h80), 8'hB1);
    check("model_and", ao211(8'h0F, 8'hFF, 8'h00, 8'h00), 8'h0F);
    check("model_zero", ao211(8'hFF, 8'h00, 8'h00, 8'h00), 8'h00);

    // Reset
    rst = 1'b1;
    step();
    step();
    #1;
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_z", z, 8'h00);
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", in_ready, 1'b1);

    // Single transfer, latency 2
    out_ready = 1'b1;
    set_ops(8'hF0, 8'h3C, 8'h01, 8'h80);
    in_valid = 1'b1;
    #1;
    check("lat_accept", in_ready, 1'b1);
    step();
    in_valid = 1'b0;
    #1;
    check("lat_cycle1_ov", out_valid, 1'b0);
    step();
    #1;
    check("lat_cycle2_ov", out_valid, 1'b1);
    check("lat_cycle2_z", z, 8'hB1);
    step();

    // Back-to-back stream of 16
    n0 = n_out;
    for (int i = 0; i < 16; i++) begin
      set_ops(W'($urandom_range(0, 255)), W'($urandom_range(0, 255)),
              W'($urandom_range(0, 255)), W'($urandom_range(0, 255)));
      in_valid = 1'b1;
      #1;
      check("stream_in_ready", in_ready, 1'b1);
      step();
    end
    in_valid = 1'b0;
    repeat (STAGES + 3) step();
    check("stream_count", n_out - n0, 16);

    // Stall, fill, then simultaneous in/out transfer on a full pipe
    out_ready = 1'b0;
    set_ops('0, '0, 8'h11, '0);
    in_valid = 1'b1;
    #1;
    check("stall_acc1", in_ready, 1'b1);
    step();
    set_ops('0, '0, 8'h22, '0);
    #1;
    check("stall_acc2", in_ready, 1'b1);
    step();
    set_ops('0, '0, 8'h33, '0);
    #1;
    check("stall_full_rdy", in_ready, 1'b0);
    check("stall_ov", out_valid, 1'b1);
    check("stall_z", z, 8'h11);
    step();
    #1;
    check("stall_hold_rdy", in_ready, 1'b0);
    check("stall_hold_z", z, 8'h11);
    out_ready = 1'b1;
    #1;
    check("full_pass_rdy", in_ready, 1'b1);
    step();
    in_valid = 1'b0;
    out_ready = 1'b0;
    #1;
    check("full_still_full", in_ready, 1'b0);
    check("full_ov", out_valid, 1'b1);
    check("full_z2", z, 8'h22);
    out_ready = 1'b1;
    step();
    #1;
    check("drain_z3", z, 8'h33);
    step();
    #1;
    check("drain_empty", out_valid, 1'b0);

    // Reset with two results in flight plus a discarded input
    out_ready = 1'b0;
    set_ops('0, '0, 8'h44, '0);
    in_valid = 1'b1;
    step();
    set_ops('0, '0, 8'h55, '0);
    step();
    set_ops('0, '0, 8'h66, '0);
    rst = 1'b1;
    #1;
    check("rst_flight_rdy", in_ready, 1'b0);
    n0 = n_out;
    step();
    rst = 1'b0;
    in_valid = 1'b0;
    #1;
    check("rst_flight_ov", out_valid, 1'b0);
    check("rst_flight_z", z, 8'h00);
    out_ready = 1'b1;
    repeat (4) step();
    check("rst_flight_dropped", n_out - n0, 0);

`ifdef LA_AO211_PIPE_STICKY_EN
    sticky_clr = 1'b1;
    step();
    sticky_clr = 1'b0;
    #1;
    check("sticky_clear", sticky, 8'h00);
    pass_through(8'h01, 1'b0);
    pass_through(8'h10, 1'b0);
    pass_through(8'h80, 1'b0);
    #1;
    check("sticky_91", sticky, 8'h91);
    pass_through(8'h04, 1'b1);
    #1;
    check("sticky_clr_wins", sticky, 8'h00);
    pass_through(8'h02, 1'b0);
    #1;
    check("sticky_02", sticky, 8'h02);
`endif

    repeat (5) step();
    check("final_empty", out_valid, 1'b0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
